// File: rtl/ram_scan_viewer.sv
// ram_scan_viewer: on-board RAM inspector. Words are written through a simple
// write port; a scan pointer walks the memory (timed or per key press, up or
// down) and the scanned address/data are shown on active-low 7-segment digits.
// Optional build macro: RAM_CLEAR_EN -- zero the whole memory after reset.
module ram_scan_viewer #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 4,
    parameter int TICK_DIV = 50000000,
    localparam int NA      = (ADDR_W + 3) / 4,
    localparam int ND      = (DATA_W + 3) / 4
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              auto_mode,
    input  logic              step,
    input  logic              dir,
    output logic [ADDR_W-1:0] view_addr,
    output logic [DATA_W-1:0] view_data,
    output logic [7*NA-1:0]   hex_addr,
    output logic [7*ND-1:0]   hex_data,
    output logic              wr_led,
    output logic              clear_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int TW    = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] scan_ptr_q, scan_ptr_d;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic              step_q, step_d;
    logic [ADDR_W-1:0] view_addr_q, view_addr_d;
    logic [DATA_W-1:0] view_data_q, view_data_d;
    logic              wr_led_q, wr_led_d;

    logic              busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic              inc, tick, step_rise;

`ifdef RAM_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

    // Clear sequencer: one address per cycle, leave CLEAR after the last word.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == CLEAR) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == '1) begin
                state_d = IDLE;
            end
        end
    end

    // Clear sequencer state; reset (re)starts the clear from address 0.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    assign busy = (state_q == CLEAR);
`else
    assign busy = 1'b0;
`endif

    // Write port select: the clear sequencer owns the port while busy.
    always_comb begin
        mem_we = wr_en;
        mem_wa = wr_addr;
        mem_wd = wr_data;
`ifdef RAM_CLEAR_EN
        if (busy) begin
            mem_we = 1'b1;
            mem_wa = clr_ptr_q;
            mem_wd = '0;
        end
`endif
    end

    // Memory write port (contents are not reset).
    always_ff @(posedge CLOCK_50) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Tick divider, step edge detect, pointer advance and registered read.
    always_comb begin
        inc       = auto_mode & ~wr_en & ~busy;
        tick      = inc && (tick_cnt_q == TICK_LAST);
        step_d    = step;
        step_rise = step & ~step_q & ~auto_mode & ~busy;

        tick_cnt_d = tick_cnt_q;
        if (inc) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        end

        scan_ptr_d = scan_ptr_q;
        if (tick || step_rise) begin
            scan_ptr_d = dir ? scan_ptr_q - 1'b1 : scan_ptr_q + 1'b1;
        end

        // Write-first bypass keeps view_data consistent with view_addr on a collision.
        view_addr_d = scan_ptr_q;
        view_data_d = (mem_we && (mem_wa == scan_ptr_q)) ? mem_wd : mem[scan_ptr_q];
        wr_led_d    = wr_en;
    end

    // Scan and view registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            scan_ptr_q  <= '0;
            tick_cnt_q  <= '0;
            step_q      <= 1'b0;
            view_addr_q <= '0;
            view_data_q <= '0;
            wr_led_q    <= 1'b0;
        end else begin
            scan_ptr_q  <= scan_ptr_d;
            tick_cnt_q  <= tick_cnt_d;
            step_q      <= step_d;
            view_addr_q <= view_addr_d;
            view_data_q <= view_data_d;
            wr_led_q    <= wr_led_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [4*NA-1:0] addr_ext;
    logic [4*ND-1:0] data_ext;

    assign addr_ext = (4*NA)'(view_addr_q);
    assign data_ext = (4*ND)'(view_data_q);

    for (genvar g = 0; g < NA; g++) begin : g_hex_addr
        assign hex_addr[7*g +: 7] = seg7(addr_ext[4*g +: 4]);
    end

    for (genvar g = 0; g < ND; g++) begin : g_hex_data
        assign hex_data[7*g +: 7] = seg7(data_ext[4*g +: 4]);
    end

    assign view_addr  = view_addr_q;
    assign view_data  = view_data_q;
    assign wr_led     = wr_led_q;
    assign clear_busy = busy;

endmodule

// File: doc/ram_scan_viewer.md
Name: ram_scan_viewer

Overview:
Parametrised on-board RAM inspector. Switch or bench stimulus writes words into an inferred single-port-write, synchronous-read memory. A scan pointer walks the memory, either automatically at a programmable tick rate or one step per key press, in either direction. The scanned address and its data are driven to active-low 7-segment digits and to raw buses for LEDs or a bench.

Parameters:
ADDR_W, 5, address width; DEPTH = 2**ADDR_W words
DATA_W, 4, data word width
TICK_DIV, 50000000, CLOCK_50 cycles per auto-scan step (>= 2)
NA, derived = (ADDR_W+3)/4, number of address hex digits
ND, derived = (DATA_W+3)/4, number of data hex digits

Ports:
CLOCK_50  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  write strobe, level; writes every cycle it is high
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
auto_mode  in  1  1 = timed scan, 0 = manual step
step  in  1  manual advance request, level from a debounced key; edge-detected internally
dir  in  1  0 = increment pointer, 1 = decrement pointer
view_addr  out  ADDR_W  address currently displayed
view_data  out  DATA_W  data at view_addr
hex_addr  out  7*NA  address digits, digit 0 in bits [6:0], least significant nibble
hex_data  out  7*ND  data digits, same packing
wr_led  out  1  equals wr_en, registered
clear_busy  out  1  memory clear in progress; see Optional Feature

Behaviour:
- Reset values: scan_ptr=0, tick_cnt=0, view_addr=0, view_data=0, wr_led=0, step_q=0, clear_busy=0. All hex digits show "0" (7'h40). Memory contents are not reset unless RAM_CLEAR_EN is defined.
- Write: when wr_en=1, mem[wr_addr] <= wr_data at the clock edge. There is no handshake.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - Increments only while auto_mode=1 and wr_en=0; it holds its value during writes.
  - tick = (tick_cnt == TICK_DIV-1) && increment condition.
  - Leaving auto mode holds tick_cnt; it does not clear it.
- Step detect: step_q <= step each cycle. step_rise = step & ~step_q, honoured only when auto_mode=0.
- Advance: when tick or step_rise occurs, scan_ptr moves by +1 (dir=0) or -1 (dir=1), modulo DEPTH.
  - Wrap cases: DEPTH-1 -> 0 going up, 0 -> DEPTH-1 going down.
  - Advance and write in the same cycle: both happen.
- Read path (registered every cycle, 1-cycle latency):
  - view_addr <= scan_ptr and view_data <= mem[scan_ptr], so view_addr and view_data are always mutually consistent.
  - Same-address read/write collision is write-first: view_data shows wr_data in the next cycle.
- Hex encoding:
  - Combinational from view_addr/view_data, per 4-bit nibble, active-low {g,f,e,d,c,b,a}.
  - Table: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E (hex).
  - The top nibble is zero-extended when the width is not a multiple of 4.
- wr_led <= wr_en.

Optional Feature:
Macro RAM_CLEAR_EN.
- Defined:
  - A two-state FSM, IDLE and CLEAR.
  - reset forces CLEAR with clr_ptr=0 and clear_busy=1.
  - Each CLEAR cycle writes mem[clr_ptr] <= 0 and increments clr_ptr.
  - After writing address DEPTH-1 the FSM goes to IDLE and clear_busy=0. The clear takes exactly DEPTH cycles after reset is released.
  - While in CLEAR: wr_en is ignored, tick_cnt and scan_ptr hold, and step edges are discarded.
  - Reset asserted mid-clear restarts the clear from address 0.
- Not defined: no FSM, clear_busy is tied to 0, and memory powers up undefined.

Test Plan:
- TICK_DIV=4, auto_mode=1, dir=0, memory preloaded mem[i]=i[3:0]:
  - Ptr advances every 4 cycles: 0,1,2,...,31,0.
  - At view_addr=0x1A, view_data=0xA, hex_addr={79,08}, hex_data=08.
- Write collision: wr_en=1, wr_addr=view_addr=3, wr_data=0xC for one cycle -> next cycle view_data=0xC and hex_data=46. tick_cnt holds its value during the write.
- Manual scan, auto_mode=0, dir=1, ptr=0: one step pulse lasting 5 cycles -> ptr=31 exactly once. A second pulse -> ptr=30.
- auto_mode=1 with step toggling -> no extra advances. Switching to auto_mode=0 at tick_cnt=2 -> tick_cnt stays at 2.
- reset asserted mid-scan at ptr=17 -> next cycle ptr=0, view_addr=0, and all hex digits=40.
- With RAM_CLEAR_EN defined, ADDR_W=5:
  - After reset release, clear_busy stays high for 32 cycles.
  - A write issued during that window is lost.
  - After clear_busy falls, every address reads 0.
